auth_resp_engine: RTL and testbench

AUTH_RESP_ENGINE -- requirements
Module: auth_resp_engine

---
 rtl/auth_pkg.sv | 38 +++
 rtl/auth_hdr_decode.sv | 51 +++++
 rtl/auth_resp_engine.sv | 183 ++++++++++++++++++
 tb/tb_auth_resp_engine.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/auth_pkg.sv
// auth_pkg: shared definitions for the authentication response engine.
//   - request / response MessageType codes
//   - error codes carried in Param1 of an error response
//   - header geometry (byte width, byte count, total bits)
//   - one-hot FSM state encodings
package auth_pkg;

  localparam int HDR_BYTE_W = 8;
  localparam int HDR_BYTES  = 4;
  localparam int HDR_W      = HDR_BYTE_W * HDR_BYTES;

  // Request MessageTypes
  localparam logic [7:0] MT_REQ_DIGESTS   = 8'h81;
  localparam logic [7:0] MT_REQ_CERT      = 8'h82;
  localparam logic [7:0] MT_REQ_CHALLENGE = 8'h83;

  // Response MessageTypes (request type with bit 7 cleared)
  localparam logic [7:0] MT_RSP_DIGESTS   = 8'h01;
  localparam logic [7:0] MT_RSP_CERT      = 8'h02;
  localparam logic [7:0] MT_RSP_CHALLENGE = 8'h03;
  localparam logic [7:0] MT_RSP_ERROR     = 8'h7F;

  // Error codes
  localparam logic [7:0] ERR_NONE        = 8'h00;
  localparam logic [7:0] ERR_INVALID_REQ = 8'h01;
  localparam logic [7:0] ERR_UNSUPPORTED = 8'h02;
  localparam logic [7:0] ERR_BUSY        = 8'h03;
  localparam logic [7:0] ERR_UNSPECIFIED = 8'h04;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_DECODE    = 5'b00010,
    ST_BACKEND   = 5'b00100,
    ST_GEN_ERROR = 5'b01000,
    ST_SEND_MSG  = 5'b10000
  } state_t;

endpackage

// File: rtl/auth_hdr_decode.sv
// auth_hdr_decode: combinational header splitter and request validator.
// Ports:
//   hdr      in   32  captured header {ProtocolVersion, MessageType, Param1, Param2}
//   be_busy  in   1   backend busy flag, folded into the error decision
//   msg_type out  8   MessageType field
//   param1   out  8   Param1 field (slot index for cert/challenge requests)
//   err_code out  8   ERR_NONE when the request may go to the backend
module auth_hdr_decode
  import auth_pkg::*;
#(
  parameter logic [7:0] PROTO_VER = 8'h01,
  parameter int         NUM_SLOTS = 8
) (
  input  logic [HDR_W-1:0] hdr,
  input  logic             be_busy,
  output logic [7:0]       msg_type,
  output logic [7:0]       param1,
  output logic [7:0]       err_code
);

  localparam logic [7:0] SLOT_LIMIT = 8'(NUM_SLOTS);

  logic [7:0] proto_ver;
  logic [7:0] unused_param2;
  logic       is_req;
  logic       needs_slot;

  assign proto_ver     = hdr[31:24];
  assign msg_type      = hdr[23:16];
  assign param1        = hdr[15:8];
  assign unused_param2 = hdr[7:0];

  assign is_req     = (msg_type == MT_REQ_DIGESTS) || (msg_type == MT_REQ_CERT) ||
                      (msg_type == MT_REQ_CHALLENGE);
  assign needs_slot = (msg_type == MT_REQ_CERT) || (msg_type == MT_REQ_CHALLENGE);

  // Priority chain: only the first failing check reports.
  always_comb begin
    err_code = ERR_NONE;
    if (proto_ver != PROTO_VER) begin
      err_code = ERR_UNSUPPORTED;
    end else if (!is_req) begin
      err_code = ERR_INVALID_REQ;
    end else if (needs_slot && (param1 >= SLOT_LIMIT)) begin
      err_code = ERR_INVALID_REQ;
    end else if (be_busy) begin
      err_code = ERR_BUSY;
    end
  end

endmodule

// File: rtl/auth_resp_engine.sv
// auth_resp_engine: accepts an authentication request, validates its header,
// fetches the response payload from a backend (with timeout) or builds an
// error response, then holds the response until the initiator acknowledges.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   resp_req_in           request valid (sampled only in IDLE)
//   auth_msg_resp_in      request message, header in the top 32 bits
//   Ack_in                initiator consumed the response (used only while presenting)
//   resp_req_out          response valid, held until Ack_in
//   auth_msg_resp_out     response message {header, payload}
//   be_busy               backend cannot accept work
//   be_req                backend request level, held until be_ack or timeout
//   be_type, be_slot      MessageType and Param1[2:0] for the backend
//   be_ack                one-cycle pulse qualifying be_payload
//   be_payload            backend response payload
module auth_resp_engine
  import auth_pkg::*;
#(
  parameter int         MSG_LEN        = 512,
  parameter int         NUM_SLOTS      = 8,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [7:0] PROTO_VER      = 8'h01
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  resp_req_in,
  input  logic [MSG_LEN-1:0]    auth_msg_resp_in,
  input  logic                  Ack_in,
  output logic                  resp_req_out,
  output logic [MSG_LEN-1:0]    auth_msg_resp_out,
  input  logic                  be_busy,
  output logic                  be_req,
  output logic [7:0]            be_type,
  output logic [2:0]            be_slot,
  input  logic                  be_ack,
  input  logic [MSG_LEN-33:0]   be_payload
);

  localparam int PAY_W = MSG_LEN - HDR_W;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state_reg, state_next;
  logic [HDR_W-1:0]   req_hdr_reg, req_hdr_next;
  logic [7:0]         err_code_reg, err_code_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [MSG_LEN-1:0] resp_msg_reg, resp_msg_next;
  logic               be_req_reg, be_req_next;
  logic [7:0]         be_type_reg, be_type_next;
  logic [2:0]         be_slot_reg, be_slot_next;
  logic               resp_req_out_reg, resp_req_out_next;
  logic [MSG_LEN-1:0] msg_out_reg, msg_out_next;

  logic [7:0] dec_type;
  logic [7:0] dec_param1;
  logic [7:0] dec_err;
  logic       unused_req_payload;

  // Only the header of the request is meaningful to this block.
  assign unused_req_payload = ^auth_msg_resp_in[PAY_W-1:0];

  auth_hdr_decode #(
    .PROTO_VER (PROTO_VER),
    .NUM_SLOTS (NUM_SLOTS)
  ) u_hdr_decode (
    .hdr      (req_hdr_reg),
    .be_busy  (be_busy),
    .msg_type (dec_type),
    .param1   (dec_param1),
    .err_code (dec_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      req_hdr_reg      <= '0;
      err_code_reg     <= ERR_NONE;
      cnt_reg          <= '0;
      resp_msg_reg     <= '0;
      be_req_reg       <= 1'b0;
      be_type_reg      <= '0;
      be_slot_reg      <= '0;
      resp_req_out_reg <= 1'b0;
      msg_out_reg      <= '0;
    end else begin
      state_reg        <= state_next;
      req_hdr_reg      <= req_hdr_next;
      err_code_reg     <= err_code_next;
      cnt_reg          <= cnt_next;
      resp_msg_reg     <= resp_msg_next;
      be_req_reg       <= be_req_next;
      be_type_reg      <= be_type_next;
      be_slot_reg      <= be_slot_next;
      resp_req_out_reg <= resp_req_out_next;
      msg_out_reg      <= msg_out_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    req_hdr_next      = req_hdr_reg;
    err_code_next     = err_code_reg;
    cnt_next          = cnt_reg;
    resp_msg_next     = resp_msg_reg;
    be_req_next       = be_req_reg;
    be_type_next      = be_type_reg;
    be_slot_next      = be_slot_reg;
    resp_req_out_next = resp_req_out_reg;
    msg_out_next      = msg_out_reg;

    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (resp_req_in) begin
          req_hdr_next = auth_msg_resp_in[MSG_LEN-1 -: HDR_W];
          state_next   = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (dec_err != ERR_NONE) begin
          err_code_next = dec_err;
          state_next    = ST_GEN_ERROR;
        end else begin
          be_req_next  = 1'b1;
          be_type_next = dec_type;
          be_slot_next = dec_param1[2:0];
          cnt_next     = '0;
          state_next   = ST_BACKEND;
        end
      end

      ST_BACKEND: begin
        // be_ack is checked first so an ack on the final cycle still wins.
        if (be_ack) begin
          be_req_next   = 1'b0;
          resp_msg_next = {PROTO_VER, dec_type & 8'h7F, dec_param1, 8'h00, be_payload};
          state_next    = ST_SEND_MSG;
        end else if (cnt_reg == CNT_LAST) begin
          be_req_next   = 1'b0;
          err_code_next = ERR_UNSPECIFIED;
          cnt_next      = cnt_reg + 1'b1;
          state_next    = ST_GEN_ERROR;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_GEN_ERROR: begin
        resp_msg_next = {PROTO_VER, MT_RSP_ERROR, err_code_reg, 8'h00, {PAY_W{1'b0}}};
        state_next    = ST_SEND_MSG;
      end

      ST_SEND_MSG: begin
        // First cycle loads the output registers; Ack_in only counts once
        // the response is actually being presented.
        if (!resp_req_out_reg) begin
          resp_req_out_next = 1'b1;
          msg_out_next      = resp_msg_reg;
        end else if (Ack_in) begin
          resp_req_out_next = 1'b0;
          msg_out_next      = '0;
          state_next        = ST_IDLE;
        end
      end

      default: begin
        state_next        = ST_IDLE;
        be_req_next       = 1'b0;
        resp_req_out_next = 1'b0;
        msg_out_next      = '0;
        cnt_next          = '0;
      end
    endcase
  end

  assign resp_req_out      = resp_req_out_reg;
  assign auth_msg_resp_out = msg_out_reg;
  assign be_req            = be_req_reg;
  assign be_type           = be_type_reg;
  assign be_slot           = be_slot_reg;

endmodule

// File: tb/tb_auth_resp_engine.sv
// tb_auth_resp_engine: directed scoreboard bench for auth_resp_engine.
// Stimulus pushes the expected response into a queue; a negedge monitor pops
// it when resp_req_out rises and checks the bus stays stable while valid.
module tb_auth_resp_engine;

  localparam int MSG_LEN = 512;
  localparam int PAY_W   = MSG_LEN - 32;

  logic               clk;
  logic               reset;
  logic               resp_req_in;
  logic [MSG_LEN-1:0] auth_msg_resp_in;
  logic               Ack_in;
  logic               resp_req_out;
  logic [MSG_LEN-1:0] auth_msg_resp_out;
  logic               be_busy;
  logic               be_req;
  logic [7:0]         be_type;
  logic [2:0]         be_slot;
  logic               be_ack;
  logic [PAY_W-1:0]   be_payload;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  logic [MSG_LEN-1:0] sb_q[$];
  logic [MSG_LEN-1:0] cur_exp;
  logic               prev_resp;
  logic               be_req_seen;

  localparam logic [PAY_W-1:0] PAY_A5 = {60{8'hA5}};
  localparam logic [PAY_W-1:0] PAY_B  = {15{32'h0BADF00D}};
  localparam logic [PAY_W-1:0] PAY_3C = {60{8'h3C}};
  localparam logic [PAY_W-1:0] PAY_5A = {60{8'h5A}};
  localparam logic [PAY_W-1:0] JUNK   = {15{32'hDEADBEEF}};

  auth_resp_engine #(
    .MSG_LEN        (MSG_LEN),
    .NUM_SLOTS      (8),
    .TIMEOUT_CYCLES (16),
    .PROTO_VER      (8'h01)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .resp_req_in       (resp_req_in),
    .auth_msg_resp_in  (auth_msg_resp_in),
    .Ack_in            (Ack_in),
    .resp_req_out      (resp_req_out),
    .auth_msg_resp_out (auth_msg_resp_out),
    .be_busy           (be_busy),
    .be_req            (be_req),
    .be_type           (be_type),
    .be_slot           (be_slot),
    .be_ack            (be_ack),
    .be_payload        (be_payload)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [MSG_LEN-1:0] act,
                       input logic [MSG_LEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  // Present one request; returns just after the capture edge.
  task automatic send_req(input logic [31:0] hdr);
    resp_req_in      = 1'b1;
    auth_msg_resp_in = {hdr, JUNK};
    wait_edge();
    resp_req_in      = 1'b0;
    auth_msg_resp_in = '0;
  endtask

  // Count edges until resp_req_out is seen high (bounded).
  task automatic wait_resp(input string name, input int exp_n);
    int n;
    n = 0;
    while (!resp_req_out && n < 50) begin
      wait_edge();
      n++;
    end
    check_int(name, n, exp_n);
  endtask

  task automatic do_ack(input string name);
    Ack_in = 1'b1;
    wait_edge();
    Ack_in = 1'b0;
    check_int({name, "_valid_after_ack"}, int'(resp_req_out), 0);
    check({name, "_bus_after_ack"}, auth_msg_resp_out, '0);
  endtask

  task automatic ack_pulse(input logic [PAY_W-1:0] pay);
    be_ack     = 1'b1;
    be_payload = pay;
    wait_edge();
    be_ack     = 1'b0;
    be_payload = '0;
  endtask

  // Scoreboard monitor
  initial begin
    prev_resp   = 1'b0;
    be_req_seen = 1'b0;
    cur_exp     = '0;
    forever begin
      @(negedge clk);
      if (be_req) be_req_seen = 1'b1;
      if (!reset && resp_req_out) begin
        if (!prev_resp) begin
          if (sb_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_resp actual=%0h required=none", auth_msg_resp_out);
          end else begin
            cur_exp = sb_q.pop_front();
            txn++;
            check("resp_msg", auth_msg_resp_out, cur_exp);
            $display("txn %0d response hdr=%08h", txn, auth_msg_resp_out[MSG_LEN-1 -: 32]);
          end
        end else begin
          check("resp_stable", auth_msg_resp_out, cur_exp);
        end
      end
      prev_resp = resp_req_out;
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset            = 1'b1;
    resp_req_in      = 1'b0;
    auth_msg_resp_in = '0;
    Ack_in           = 1'b0;
    be_busy          = 1'b0;
    be_ack           = 1'b0;
    be_payload       = '0;
    repeat (3) wait_edge();
    check_int("rst_valid", int'(resp_req_out), 0);
    check("rst_bus", auth_msg_resp_out, '0);
    check_int("rst_be_req", int'(be_req), 0);
    check_int("rst_be_type", int'(be_type), 0);
    check_int("rst_be_slot", int'(be_slot), 0);
    reset = 1'b0;
    wait_edge();

    // 1: digests request, ack after 5 cycles
    sb_q.push_back({32'h01010000, PAY_A5});
    send_req(32'h01810000);
    wait_edge();
    check_int("t1_be_req", int'(be_req), 1);
    check_int("t1_be_type", int'(be_type), 8'h81);
    check_int("t1_be_slot", int'(be_slot), 0);
    repeat (4) wait_edge();
    check_int("t1_be_req_held", int'(be_req), 1);
    ack_pulse(PAY_A5);
    check_int("t1_be_req_drop", int'(be_req), 0);
    wait_resp("t1_latency", 1);
    repeat (3) wait_edge();
    check_int("t1_valid_held", int'(resp_req_out), 1);
    do_ack("t1");

    // 2: unsupported protocol
    be_req_seen = 1'b0;
    sb_q.push_back({32'h017F0200, {PAY_W{1'b0}}});
    send_req(32'h02810000);
    wait_resp("t2_latency", 3);
    check_int("t2_no_be_req", int'(be_req_seen), 0);
    do_ack("t2");

    // 3a: slot out of range
    sb_q.push_back({32'h017F0100, {PAY_W{1'b0}}});
    send_req(32'h01820900);
    wait_resp("t3a_latency", 3);
    do_ack("t3a");

    // 3b: backend busy
    be_busy = 1'b1;
    sb_q.push_back({32'h017F0300, {PAY_W{1'b0}}});
    send_req(32'h01830000);
    wait_resp("t3b_latency", 3);
    be_busy = 1'b0;
    do_ack("t3b");

    // 4a: backend timeout after 16 cycles
    begin
      int n;
      sb_q.push_back({32'h017F0400, {PAY_W{1'b0}}});
      send_req(32'h01830200);
      wait_edge();
      check_int("t4a_be_req", int'(be_req), 1);
      check_int("t4a_be_slot", int'(be_slot), 2);
      n = 0;
      while (be_req && n < 40) begin
        wait_edge();
        n++;
      end
      check_int("t4a_be_req_cycles", n, 16);
      wait_resp("t4a_latency", 2);
      do_ack("t4a");
    end

    // 4b: be_ack on the 16th cycle beats the timeout
    sb_q.push_back({32'h01030200, PAY_B});
    send_req(32'h01830200);
    wait_edge();
    repeat (15) wait_edge();
    check_int("t4b_be_req_before", int'(be_req), 1);
    ack_pulse(PAY_B);
    check_int("t4b_be_req_drop", int'(be_req), 0);
    wait_resp("t4b_latency", 1);
    do_ack("t4b");

    // 5: reset mid-backend, then a normal transaction
    send_req(32'h01810000);
    repeat (3) wait_edge();
    check_int("t5_be_req_pre", int'(be_req), 1);
    reset = 1'b1;
    wait_edge();
    reset = 1'b0;
    check_int("t5_be_req_rst", int'(be_req), 0);
    check_int("t5_be_type_rst", int'(be_type), 0);
    check_int("t5_valid_rst", int'(resp_req_out), 0);
    sb_q.push_back({32'h01020300, PAY_3C});
    send_req(32'h01820300);
    wait_edge();
    check_int("t5_be_slot", int'(be_slot), 3);
    wait_edge();
    ack_pulse(PAY_3C);
    wait_resp("t5_latency", 1);
    do_ack("t5");

    // 6: long hold with a stray request during SEND_MSG
    sb_q.push_back({32'h01010000, PAY_5A});
    send_req(32'h01810000);
    wait_edge();
    ack_pulse(PAY_5A);
    wait_resp("t6_latency", 1);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        resp_req_in      = 1'b1;
        auth_msg_resp_in = {32'h02810000, JUNK};
      end else begin
        resp_req_in      = 1'b0;
        auth_msg_resp_in = '0;
      end
      wait_edge();
    end
    check_int("t6_valid_held", int'(resp_req_out), 1);
    check("t6_bus_held", auth_msg_resp_out, {32'h01010000, PAY_5A});
    do_ack("t6");
    be_req_seen = 1'b0;
    repeat (10) wait_edge();
    check_int("t6_stray_valid", int'(resp_req_out), 0);
    check_int("t6_stray_be_req", int'(be_req_seen), 0);
    check_int("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
